// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: sequencer and arbiter for the hardware return-address stack shared by cpu and irq.
// Define CALL_STACK_RR_EN for round-robin conflict arbitration; otherwise irq has fixed priority.
module call_stack_ctrl #(
  parameter int AW = 5,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_op,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          irq_req,
  input  logic          irq_op,
  input  logic [DW-1:0] irq_wdata,
  output logic          irq_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] sp,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  typedef enum logic [2:0] {IDLE, PUSH, POP_RD, POP_WAIT, ERR} state_t;

  localparam logic [AW-1:0] SP_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};

  state_t        state, state_nxt;
  logic          sel_irq;
  logic          sel_op;
  logic [DW-1:0] sel_wdata;
  logic          any_req;
  logic          gnt_irq;
  logic          op_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          ack_now;

  assign any_req = cpu_req | irq_req;
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);

`ifdef CALL_STACK_RR_EN
  // last_irq remembers the winner of the most recent conflict only.
  logic last_irq;

  always_comb sel_irq = irq_req & (~cpu_req | ~last_irq);

  always_ff @(posedge clk) begin
    if (reset)
      last_irq <= 1'b1;
    else if (state == IDLE && cpu_req && irq_req)
      last_irq <= sel_irq;
  end
`else
  always_comb sel_irq = irq_req;
`endif

  assign sel_op    = sel_irq ? irq_op    : cpu_op;
  assign sel_wdata = sel_irq ? irq_wdata : cpu_wdata;

  // Grant capture: requester identity, op and push data held for the whole operation.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      gnt_irq <= sel_irq;
      op_q    <= sel_op;
      wdata_q <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_op && !full)       state_nxt = PUSH;
          else if (!sel_op && !empty) state_nxt = POP_RD;
          else                        state_nxt = ERR;
        end
      end
      POP_RD:   state_nxt = POP_WAIT;
      PUSH,
      POP_WAIT,
      ERR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = (state == PUSH);
    mem_re    = (state == POP_RD);
    mem_addr  = (state == POP_RD) ? (sp - SP_ONE) : sp;
    mem_wdata = wdata_q;
    ack_now   = (state == PUSH) || (state == POP_WAIT) || (state == ERR);
    cpu_ack   = ack_now & ~gnt_irq;
    irq_ack   = ack_now &  gnt_irq;
    // Pop data is forwarded in the ack cycle and held afterwards.
    rdata     = (state == POP_WAIT) ? mem_rdata : rdata_q;
  end

  // Pointer / count update: only completed RAM operations move them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp      <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        PUSH: begin
          sp    <= sp + SP_ONE;
          count <= count + CNT_ONE;
        end
        POP_WAIT: begin
          sp      <= sp - SP_ONE;
          count   <= count - CNT_ONE;
          rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags: a new error overrides a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (err_clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      if (state == ERR) begin
        if (op_q) ovf <= 1'b1;
        else      udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed scenarios plus randomized ops against a queue-based stack model.
module tb_call_stack_ctrl;
  localparam int AW = 5;
  localparam int DW = 10;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_op = 1'b0, irq_req = 1'b0, irq_op = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] cpu_wdata = '0, irq_wdata = '0;
  logic          cpu_ack, irq_ack, mem_we, mem_re, full, empty, ovf, udf;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr, sp;
  logic [AW:0]   count;

  logic [DW-1:0] ram [DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model: a queue is the stack; sp equals entry count modulo depth.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_udf, m_last_irq;
  logic [DW-1:0] m_rdata;

  call_stack_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .irq_req(irq_req), .irq_op(irq_op), .irq_wdata(irq_wdata), .irq_ack(irq_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .sp(sp), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset = 1'b1; cpu_req = 1'b0; irq_req = 1'b0; err_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    m_ovf = 0; m_udf = 0; m_rdata = '0; m_last_irq = 1;
  endtask

  // Drives one request and waits (bounded) for its ack; lat is the ack cycle index or -1.
  task automatic run_op(input bit use_irq, input bit op, input logic [DW-1:0] d,
                        output int lat, output bit we_seen, output bit re_seen,
                        output logic [AW-1:0] waddr, output logic [DW-1:0] wdat,
                        output logic [DW-1:0] rd, output bit bad);
    lat = -1; we_seen = 0; re_seen = 0; waddr = '0; wdat = '0; rd = '0; bad = 0;
    if (use_irq) begin irq_req = 1'b1; irq_op = op; irq_wdata = d; end
    else         begin cpu_req = 1'b1; cpu_op = op; cpu_wdata = d; end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_we) begin we_seen = 1; waddr = mem_addr; wdat = mem_wdata; end
      if (mem_re) re_seen = 1;
      if (mem_we && mem_re) bad = 1;
      if (use_irq ? cpu_ack : irq_ack) bad = 1;
      if (use_irq ? irq_ack : cpu_ack) begin lat = c; rd = rdata; break; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; irq_req = 1'b0;
  endtask

  task automatic model_op(input bit op, input logic [DW-1:0] d, output int exp_lat,
                          output bit exp_we, output bit exp_re, output logic [AW-1:0] exp_addr);
    exp_we = 0; exp_re = 0; exp_addr = AW'(mq.size() % DEPTH); exp_lat = 1;
    if (op) begin
      if (mq.size() < DEPTH) begin exp_we = 1; mq.push_back(d); end
      else m_ovf = 1;
    end else begin
      if (mq.size() > 0) begin exp_re = 1; exp_lat = 2; m_rdata = mq.pop_back(); end
      else m_udf = 1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (sp !== '0) begin errors++; $display("FAIL reset_sp: got %0d expected 0", sp); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({empty, full} !== 2'b10) begin errors++; $display("FAIL reset_flags empty/full: got %b expected 10", {empty, full}); end
    checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {ovf, udf}); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", rdata); end
    checks++; if ({cpu_ack, irq_ack, mem_we, mem_re} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {cpu_ack, irq_ack, mem_we, mem_re}); end
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop();
    int lat; bit we, re, bad; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
    apply_reset();
    run_op(0, 1, 10'h155, lat, we, re, wa, wd, rd, bad);
    checks++; if (lat !== 1) begin errors++; $display("FAIL push_lat: got %0d expected 1", lat); end
    checks++; if ({we, wa, wd} !== {1'b1, 5'd0, 10'h155}) begin errors++; $display("FAIL push_write: got we=%b addr=%0d data=%0h expected we=1 addr=0 data=155", we, wa, wd); end
    checks++; if ({sp, count} !== {5'd1, 6'd1}) begin errors++; $display("FAIL push_ptr: got sp=%0d count=%0d expected 1 1", sp, count); end
    run_op(0, 0, 10'h0, lat, we, re, wa, wd, rd, bad);
    checks++; if (lat !== 2) begin errors++; $display("FAIL pop_lat: got %0d expected 2", lat); end
    checks++; if (rd !== 10'h155) begin errors++; $display("FAIL pop_rdata: got %0h expected 155", rd); end
    checks++; if ({sp, empty, re, bad} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL pop_state: got sp=%0d empty=%b re=%b bad=%b expected 0 1 1 0", sp, empty, re, bad); end
  endtask

  task automatic test_fill_overflow();
    int lat; bit we, re, bad; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
    int e0 = 0;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      run_op(i % 2, 1, DW'(i), lat, we, re, wa, wd, rd, bad);
      if (lat != 1 || !we || wa != AW'(i) || wd != DW'(i)) e0++;
    end
    checks++; if (e0 !== 0) begin errors++; $display("FAIL fill_pushes: got %0d bad pushes expected 0", e0); end
    checks++; if ({full, sp, count} !== {1'b1, 5'd0, 6'd32}) begin errors++; $display("FAIL fill_full: got full=%b sp=%0d count=%0d expected 1 0 32", full, sp, count); end
    run_op(0, 1, 10'h3FF, lat, we, re, wa, wd, rd, bad);
    checks++; if ({lat == 1, we} !== 2'b10) begin errors++; $display("FAIL ovf_push: got lat=%0d we=%b expected lat=1 we=0", lat, we); end
    checks++; if ({ovf, udf, count, sp} !== {1'b1, 1'b0, 6'd32, 5'd0}) begin errors++; $display("FAIL ovf_state: got ovf=%b udf=%b count=%0d sp=%0d expected 1 0 32 0", ovf, udf, count, sp); end
    e0 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      run_op(i % 2, 0, '0, lat, we, re, wa, wd, rd, bad);
      if (lat != 2 || rd != DW'(DEPTH - 1 - i) || bad) e0++;
    end
    checks++; if (e0 !== 0) begin errors++; $display("FAIL drain_pops: got %0d bad pops expected 0", e0); end
    checks++; if ({empty, sp, count} !== {1'b1, 5'd0, 6'd0}) begin errors++; $display("FAIL drain_empty: got empty=%b sp=%0d count=%0d expected 1 0 0", empty, sp, count); end
  endtask

  task automatic test_underflow();
    int lat; bit we, re, bad; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
    apply_reset();
    run_op(1, 0, '0, lat, we, re, wa, wd, rd, bad);
    checks++; if ({lat == 1, re, we} !== 3'b100) begin errors++; $display("FAIL udf_pop: got lat=%0d re=%b we=%b expected lat=1 re=0 we=0", lat, re, we); end
    checks++; if ({udf, ovf, sp, count, rd} !== {1'b1, 1'b0, 5'd0, 6'd0, 10'h0}) begin errors++; $display("FAIL udf_state: got udf=%b ovf=%b sp=%0d count=%0d rd=%0h expected 1 0 0 0 0", udf, ovf, sp, count, rd); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", udf); end
  endtask

  task automatic test_conflict();
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      int cc, ic, nw;
      bit win_irq;
      logic [DW-1:0] wds [2];
      logic [DW-1:0] cd, id;
`ifdef CALL_STACK_RR_EN
      win_irq = !m_last_irq;
      m_last_irq = win_irq;
`else
      win_irq = 1;
`endif
      cd = DW'(10'h0A0 + rep); id = DW'(10'h3C0 + rep);
      cc = -1; ic = -1; nw = 0; wds[0] = '0; wds[1] = '0;
      cpu_req = 1'b1; cpu_op = 1'b1; cpu_wdata = cd;
      irq_req = 1'b1; irq_op = 1'b1; irq_wdata = id;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (cpu_ack && cc < 0) cc = c;
        if (irq_ack && ic < 0) ic = c;
        if (mem_we && nw < 2) begin wds[nw] = mem_wdata; nw++; end
        @(posedge clk); #1;
        if (cc >= 0) cpu_req = 1'b0;
        if (ic >= 0) irq_req = 1'b0;
        if (cc >= 0 && ic >= 0) break;
      end
      checks++; if ((win_irq ? ic : cc) !== 1) begin errors++; $display("FAIL conflict_winner_ack rep%0d: got cycle %0d expected 1", rep, win_irq ? ic : cc); end
      checks++; if ((win_irq ? cc : ic) !== 3) begin errors++; $display("FAIL conflict_loser_ack rep%0d: got cycle %0d expected 3", rep, win_irq ? cc : ic); end
      checks++; if ({wds[0], wds[1]} !== (win_irq ? {id, cd} : {cd, id})) begin errors++; $display("FAIL conflict_order rep%0d: got %0h,%0h expected winner first", rep, wds[0], wds[1]); end
    end
    checks++; if (count !== 6'd4) begin errors++; $display("FAIL conflict_count: got %0d expected 4", count); end
  endtask

  task automatic test_reset_mid_pop();
    int lat; bit we, re, bad; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
    bit acked = 0;
    apply_reset();
    run_op(0, 1, 10'h2AA, lat, we, re, wa, wd, rd, bad);
    cpu_req = 1'b1; cpu_op = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    if (cpu_ack) acked = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); m_ovf = 0; m_udf = 0; m_rdata = '0; m_last_irq = 1;
    @(negedge clk);
    if (cpu_ack || irq_ack) acked = 1;
    checks++; if (acked !== 1'b0) begin errors++; $display("FAIL midreset_ack: got ack=%b expected 0", acked); end
    checks++; if ({sp, count} !== {5'd0, 6'd0}) begin errors++; $display("FAIL midreset_ptr: got sp=%0d count=%0d expected 0 0", sp, count); end
    @(posedge clk); #1;
    run_op(0, 1, 10'h0F0, lat, we, re, wa, wd, rd, bad);
    checks++; if ({lat == 1, we, wa, count} !== {1'b1, 1'b1, 5'd0, 6'd1}) begin errors++; $display("FAIL midreset_push: got lat=%0d we=%b addr=%0d count=%0d expected 1 1 0 1", lat, we, wa, count); end
  endtask

  task automatic test_errclr_setwins();
    int lat; bit we, re, bad; logic [AW-1:0] wa; logic [DW-1:0] wd, rd;
    bit acked;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) run_op(0, 1, DW'(i + 100), lat, we, re, wa, wd, rd, bad);
    cpu_req = 1'b1; cpu_op = 1'b1; cpu_wdata = 10'h111;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(negedge clk);
    acked = cpu_ack;
    @(posedge clk); #1;
    err_clr = 1'b0; cpu_req = 1'b0;
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL setwins_ack: got %b expected 1", acked); end
    checks++; if ({ovf, udf, count} !== {1'b1, 1'b0, 6'd32}) begin errors++; $display("FAIL setwins_flags: got ovf=%b udf=%b count=%0d expected 1 0 32", ovf, udf, count); end
  endtask

  task automatic test_random();
    int lat, elat; bit we, re, bad, ewe, ere; logic [AW-1:0] wa, ewa; logic [DW-1:0] wd, rd, d;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 5) begin
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_ovf = 0; m_udf = 0;
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL rnd_errclr n=%0d: got %b expected 00", n, {ovf, udf}); end
      end else begin
        bit op, ui;
        op = ((n / 60) % 2 == 0) ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 25);
        ui = 1'($urandom_range(0, 1));
        d = DW'($urandom);
        model_op(op, d, elat, ewe, ere, ewa);
        run_op(ui, op, d, lat, we, re, wa, wd, rd, bad);
        checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_lat n=%0d op=%b: got %0d expected %0d", n, op, lat, elat); end
        checks++; if ({we, re, bad} !== {ewe, ere, 1'b0}) begin errors++; $display("FAIL rnd_mem n=%0d: got we=%b re=%b bad=%b expected we=%b re=%b bad=0", n, we, re, bad, ewe, ere); end
        if (ewe) begin
          checks++; if ({wa, wd} !== {ewa, d}) begin errors++; $display("FAIL rnd_write n=%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", n, wa, wd, ewa, d); end
        end
        checks++; if (rd !== m_rdata) begin errors++; $display("FAIL rnd_rdata n=%0d: got %0h expected %0h", n, rd, m_rdata); end
        checks++; if ({sp, count} !== {AW'(mq.size() % DEPTH), 6'(mq.size())}) begin errors++; $display("FAIL rnd_ptr n=%0d: got sp=%0d count=%0d expected %0d %0d", n, sp, count, mq.size() % DEPTH, mq.size()); end
        checks++; if ({full, empty, ovf, udf} !== {mq.size() == DEPTH, mq.size() == 0, m_ovf, m_udf}) begin errors++; $display("FAIL rnd_flags n=%0d: got full/empty/ovf/udf=%b expected %b", n, {full, empty, ovf, udf}, {mq.size() == DEPTH, mq.size() == 0, m_ovf, m_udf}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_fill_overflow();
    test_underflow();
    test_conflict();
    test_reset_mid_pop();
    test_errclr_setwins();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
- Sequencer and arbiter for the 32-entry hardware return-address stack.
- Owns the stack pointer register and entry count, and drives the synchronous stack RAM.
- Shares the stack between two requesters: the core's call/return path (cpu) and the interrupt entry/exit path (irq).
- Detects overflow and underflow, and never corrupts the RAM or the pointer on either.

Parameters:
- AW, 5, stack address width; depth = 2**AW.
- DW, 10, return-address width (program-counter width).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  cpu requests an operation; held until cpu_ack.
- cpu_op  in  1  1 = push, 0 = pop; stable while cpu_req is high.
- cpu_wdata  in  DW  push data.
- cpu_ack  out  1  one-cycle completion pulse to cpu.
- irq_req  in  1  irq requests an operation; same rules as cpu_req.
- irq_op  in  1  1 = push, 0 = pop.
- irq_wdata  in  DW  push data.
- irq_ack  out  1  one-cycle completion pulse to irq.
- rdata  out  DW  pop result; valid in the cycle of the matching ack, held until the next pop completes.
- mem_addr  out  AW  stack RAM address.
- mem_we  out  1  stack RAM write enable.
- mem_wdata  out  DW  stack RAM write data.
- mem_re  out  1  stack RAM read enable; mem_rdata is valid the next cycle.
- mem_rdata  in  DW  stack RAM read data.
- sp  out  AW  stack pointer: next free slot, wraps mod 2**AW.
- count  out  AW+1  number of entries, 0..2**AW.
- full  out  1  count == 2**AW.
- empty  out  1  count == 0.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.
- err_clr  in  1  clears ovf and udf.

Behaviour:
- Reset values: state IDLE, sp=0, count=0, rdata=0, ovf=0, udf=0, both acks 0, mem_we=0, mem_re=0. Stack RAM contents are not cleared.
- A reset in mid-operation aborts the operation: no ack is issued, and no pointer or count update occurs.
- FSM states: IDLE, PUSH, POP_RD, POP_WAIT, ERR.
- IDLE:
  - If any req is high, grant one requester and latch its op and wdata.
  - Next state: PUSH if push and not full; POP_RD if pop and not empty; ERR otherwise.
  - With no req, remain in IDLE.
- PUSH:
  - mem_we=1, mem_addr=sp, mem_wdata=latched data.
  - Pulse the granted ack; sp<=sp+1 and count<=count+1.
  - Next state IDLE.
  - Latency: req sampled in cycle 0, ack in cycle 1.
- POP_RD:
  - mem_re=1, mem_addr=sp-1 (mod 2**AW).
  - Next state POP_WAIT.
- POP_WAIT:
  - rdata<=mem_rdata; pulse the granted ack; sp<=sp-1 and count<=count-1.
  - Next state IDLE.
  - Latency: ack in cycle 2.
- ERR:
  - No RAM access; sp and count unchanged.
  - Pulse the granted ack; push sets ovf, pop sets udf; rdata unchanged.
  - Next state IDLE.
- At most one operation is in flight; mem_we and mem_re are never high together.
- Arbitration:
  - Only evaluated in IDLE; both req high at once counts as a conflict.
  - The default is fixed priority, irq over cpu.
  - A req still high in the cycle after its ack is treated as a new request.
- Pointer arithmetic: sp wraps modulo 2**AW. Wrap-around is not an error; only count governs full and empty.
- full and empty are combinational from count.
- err_clr in the same cycle as a new error: the set wins.
- No ack is generated for a requester that was not granted.

Optional Feature:
- Macro: CALL_STACK_RR_EN.
- Defined: round-robin arbitration. On a conflict, the requester not granted last wins. The last-grant register resets to irq, so cpu wins the first conflict after reset.
- Undefined: fixed priority, irq always wins a conflict. No last-grant register is built.

Test Plan:
- Reset, then a cpu push of 10'h155 → cpu_ack in cycle 1, mem_we=1 at mem_addr=0, sp=1, count=1; a cpu pop then gives cpu_ack 2 cycles after req with rdata=10'h155, sp=0, empty=1.
- 32 pushes of values 0..31, then a 33rd push → full=1 after the 32nd push, sp=0 (wrapped); the 33rd push acks with no mem_we, ovf=1, count=32. Then 32 pops return 31..0 in order.
- Pop on an empty stack → ack one cycle after req, mem_re never asserted, udf=1, sp=0, count=0. err_clr for one cycle then clears udf to 0.
- cpu and irq requests high in the same cycle (both push) → without CALL_STACK_RR_EN, irq is acked first and cpu next. With it, cpu is acked first after reset; a repeat conflict then grants irq first.
- reset asserted in the POP_RD cycle → no ack, sp and count keep their reset values of 0, state IDLE; a subsequent push completes normally.
- err_clr in the same cycle that an overflow push reaches ERR → ovf=1 afterwards (set wins).
